// File: rtl/oled_init_pkg.sv
// oled_init_pkg: entry type codes, protocol byte constants and the power-up ROM contents.
package oled_init_pkg;

    localparam logic [1:0] T_EMIT  = 2'b00;
    localparam logic [1:0] T_DELAY = 2'b01;
    localparam logic [1:0] T_END   = 2'b10;

    // Flag bytes are 001abcde with a=CS, b=DC, c=RES, d=VBATC, e=VDDC.
    localparam logic [7:0] FLAGS_OFF  = 8'h37;
    localparam logic [7:0] FLAGS_VDD  = 8'h36;
    localparam logic [7:0] FLAGS_RES  = 8'h32;
    localparam logic [7:0] FLAGS_CSL  = 8'h26;
    localparam logic [7:0] FLAGS_VBAT = 8'h24;
    localparam logic [7:0] SPI_OP     = 8'h10;
    localparam logic [7:0] DISP_OFF   = 8'hAE;
    localparam logic [7:0] DISP_ON    = 8'hAF;

    function automatic logic [9:0] rom_word(input int unsigned addr);
        case (addr)
            0:       rom_word = {T_EMIT, FLAGS_OFF};
            1:       rom_word = {T_EMIT, FLAGS_VDD};
            2:       rom_word = {T_DELAY, 8'd1};
            3:       rom_word = {T_EMIT, FLAGS_RES};
            4:       rom_word = {T_DELAY, 8'd1};
            5:       rom_word = {T_EMIT, FLAGS_VDD};
            6:       rom_word = {T_DELAY, 8'd1};
            7:       rom_word = {T_EMIT, FLAGS_CSL};
            8:       rom_word = {T_EMIT, SPI_OP};
            9:       rom_word = {T_EMIT, DISP_OFF};
            10:      rom_word = {T_EMIT, FLAGS_VBAT};
            11:      rom_word = {T_DELAY, 8'd100};
            12:      rom_word = {T_EMIT, SPI_OP};
            13:      rom_word = {T_EMIT, DISP_ON};
            14:      rom_word = {T_EMIT, FLAGS_OFF};
            default: rom_word = {T_END, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// oled_init_rom: combinational address-to-word lookup of the init sequence.
module oled_init_rom
    import oled_init_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] addr,
    output logic [9:0]    word
);

    assign word = rom_word(32'(addr));

endmodule

// File: rtl/oled_init_seq.sv
// oled_init_seq: ROM-driven power-up sequencer feeding the PMOD OLED bridge byte input.
module oled_init_seq
    import oled_init_pkg::*;
#(
    parameter int CYC_PER_MS = 12000,
    parameter int BYTE_GAP   = 32,
    parameter int ROM_AW     = 5
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       start,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(255 * CYC_PER_MS + BYTE_GAP + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EMIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DELAY = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state;
    logic [ROM_AW-1:0] addr;
    logic [CW-1:0]     count;
    logic [9:0]        word;
    logic [1:0]        kind;

    oled_init_rom #(.AW(ROM_AW)) u_rom (.addr(addr), .word(word));

    // The last slot always ends the run so the address never wraps mid-sequence.
    assign kind = (addr == {ROM_AW{1'b1}}) ? T_END : word[9:8];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state     <= S_IDLE;
            addr      <= '0;
            count     <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr  <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (kind == T_EMIT) begin
                        addr      <= addr + 1'b1;
                        out_data  <= word[7:0];
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else if (kind == T_DELAY) begin
                        addr  <= addr + 1'b1;
                        count <= CW'(32'(word[7:0]) * CYC_PER_MS);
                        state <= (word[7:0] == 8'd0) ? S_FETCH : S_DELAY;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count     <= CW'(BYTE_GAP);
                        state     <= S_GAP;
                    end
                end
                // Leaving at a count of 1 makes the counter span exactly its loaded number of cycles.
                S_GAP, S_DELAY: begin
                    count <= count - 1'b1;
                    if (count <= CW'(1))
                        state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
